// File: rtl/field_extractor_pkg.sv
// Shared types for the field extractor: action/descriptor layout, size codes,
// FSM states and the header byte-select helper.
package field_extractor_pkg;
  localparam int ACT_W     = 125;
  localparam int BID_W     = 5;
  localparam int HDR_BYTES = 64;
  localparam int HDR_W     = HDR_BYTES * 8;
  localparam int NFIELD    = 8;
  localparam int DESC_W    = 12;
  localparam int FIELD_W   = 32;

  typedef enum logic [1:0] {SZ_1B = 2'd0, SZ_2B = 2'd1, SZ_4B = 2'd2, SZ_4B_ALT = 2'd3} size_e;

  typedef struct packed {
    size_e      size;
    logic [1:0] rsv;
    logic [7:0] off;
  } desc_t;

  typedef struct packed {
    logic [BID_W-1:0]       bid;
    logic [7:0]             next_state;
    logic [7:0]             type_loc;
    logic [NFIELD-1:0]      field_mask;
    desc_t [NFIELD-1:0]     desc;
  } action_t;

  typedef enum logic [1:0] {S_IDLE, S_EXTRACT, S_DONE} state_e;

  // Byte 0 is the most significant byte of the header; offsets past the end read as zero.
  function automatic logic [7:0] hdr_byte(input logic [HDR_W-1:0] h, input logic [8:0] idx);
    logic [7:0] b;
    b = '0;
    if (idx < 9'(HDR_BYTES)) b = h[(HDR_BYTES-1-int'(idx[5:0]))*8 +: 8];
    return b;
  endfunction
endpackage

// File: rtl/field_extractor_if.sv
// Header/action input and metadata output bundle of the field extractor.
interface field_extractor_if;
  import field_extractor_pkg::*;
  logic                     hdr_valid;
  logic [BID_W-1:0]         hdr_bid;
  logic [HDR_W-1:0]         hdr_data;
  logic                     action_valid;
  logic [ACT_W-1:0]         action;
  logic                     meta_valid;
  logic [BID_W-1:0]         meta_bid;
  logic [15:0]              meta_key;
  logic [NFIELD-1:0]        meta_fvld;
  logic [NFIELD*FIELD_W-1:0] meta_fields;
  logic                     meta_err;
  logic                     ovf_err;

  modport master (output hdr_valid, hdr_bid, hdr_data, action_valid, action,
                  input  meta_valid, meta_bid, meta_key, meta_fvld, meta_fields, meta_err, ovf_err);
  modport slave  (input  hdr_valid, hdr_bid, hdr_data, action_valid, action,
                  output meta_valid, meta_bid, meta_key, meta_fvld, meta_fields, meta_err, ovf_err);
endinterface

// File: rtl/field_extractor_act_fifo.sv
// Synchronous action FIFO; caller only asserts push when there is room or a pop shares the edge.
module act_fifo #(
  parameter int WIDTH = 125,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 2**AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/field_extractor.sv
// Pulls up to eight descriptor-selected fields from a buffered header per queued action
// and emits one metadata record every ten cycles.
module field_extractor
  import field_extractor_pkg::*;
#(
  parameter int FIFO_AW = 2,
  parameter int SLOT_AW = 2
) (
  input  logic             clk,
  input  logic             reset,
  field_extractor_if.slave bus
);
  logic [HDR_W-1:0] slots [2**SLOT_AW];
  logic [HDR_W-1:0] hdr_work, load_hdr;
  logic [ACT_W-1:0] fifo_q;
  action_t          fifo_dout, act_q;
  logic             push, pop, full, empty;
  state_e           state, state_n;
  logic [2:0]       cnt;
  logic [7:0]       type_q;
  logic             err_q, ovf_q;
  logic [NFIELD-1:0][FIELD_W-1:0] fields_q, meta_fields_q;

  logic             meta_valid_q, meta_err_q;
  logic [BID_W-1:0] meta_bid_q;
  logic [15:0]      meta_key_q;
  logic [NFIELD-1:0] meta_fvld_q;

  // Upstream has no backpressure: a full FIFO still accepts when the FSM pops on the same edge.
  assign push = bus.action_valid && (!full || pop);

  act_fifo #(.WIDTH(ACT_W), .AW(FIFO_AW)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .din(bus.action), .dout(fifo_q), .full(full), .empty(empty)
  );
  assign fifo_dout = fifo_q;
  assign load_hdr  = slots[fifo_dout.bid[SLOT_AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      S_IDLE:    if (!empty) begin pop = 1'b1; state_n = S_EXTRACT; end
      S_EXTRACT: if (cnt == 3'd7) state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  desc_t           cur;
  logic [3:0][8:0] idx;
  logic [3:0][7:0] fb;
  logic [3:0]      oob;
  logic [31:0]     field_val;
  logic            field_err;
  logic            unused_bits;

  // Fetch four consecutive bytes at the current descriptor's offset; size picks how many count.
  always_comb begin
    cur       = act_q.desc[cnt];
    field_val = '0;
    field_err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx[k] = {1'b0, cur.off} + 9'(k);
      fb[k]  = hdr_byte(hdr_work, idx[k]);
      oob[k] = (idx[k] >= 9'(HDR_BYTES));
    end
    if (act_q.field_mask[cnt]) begin
      case (cur.size)
        SZ_1B:   begin field_val = {24'h0, fb[0]};        field_err = oob[0]; end
        SZ_2B:   begin field_val = {16'h0, fb[0], fb[1]}; field_err = |oob[1:0]; end
        default: begin field_val = {fb[0], fb[1], fb[2], fb[3]}; field_err = |oob; end
      endcase
    end
  end
  assign unused_bits = ^{cur.rsv, bus.hdr_bid};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 2**SLOT_AW; s++) slots[s] <= '0;
      hdr_work      <= '0;
      act_q         <= '0;
      cnt           <= '0;
      type_q        <= '0;
      err_q         <= 1'b0;
      fields_q      <= '0;
      ovf_q         <= 1'b0;
      meta_valid_q  <= 1'b0;
      meta_bid_q    <= '0;
      meta_key_q    <= '0;
      meta_fvld_q   <= '0;
      meta_fields_q <= '0;
      meta_err_q    <= 1'b0;
    end else begin
      if (bus.hdr_valid) slots[bus.hdr_bid[SLOT_AW-1:0]] <= bus.hdr_data;
      if (bus.action_valid && full && !pop) ovf_q <= 1'b1;
      meta_valid_q <= 1'b0;
      case (state)
        S_IDLE: if (pop) begin
          // Snapshot the slot so later header writes cannot disturb this record.
          act_q    <= fifo_dout;
          hdr_work <= load_hdr;
          type_q   <= hdr_byte(load_hdr, {1'b0, fifo_dout.type_loc});
          err_q    <= (fifo_dout.type_loc >= 8'(HDR_BYTES));
          fields_q <= '0;
          cnt      <= '0;
        end
        S_EXTRACT: begin
          fields_q[cnt] <= field_val;
          err_q         <= err_q | field_err;
          cnt           <= cnt + 3'd1;
        end
        S_DONE: begin
          meta_valid_q  <= 1'b1;
          meta_bid_q    <= act_q.bid;
          meta_key_q    <= {act_q.next_state, type_q};
          meta_fvld_q   <= act_q.field_mask;
          meta_fields_q <= fields_q;
          meta_err_q    <= err_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.meta_valid  = meta_valid_q;
  assign bus.meta_bid    = meta_bid_q;
  assign bus.meta_key    = meta_key_q;
  assign bus.meta_fvld   = meta_fvld_q;
  assign bus.meta_fields = meta_fields_q;
  assign bus.meta_err    = meta_err_q;
  assign bus.ovf_err     = ovf_q;
endmodule
